mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU controller (fetch, load and store) and a debug/program-loader port.
- Grants one transaction at a time using round-robin priority.
- Sequences the memory access: enable, byte-lane generation for word/byte stores, and wait for fixed read latency.
- Returns a completion pulse and read data to the requester that owns the transaction.

Parameters:
AW, 10, word-address width of the memory (mem_addr = addr[AW+1:2])
MEM_LAT, 1, memory read latency in cycles, legal range 1..7

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  one clock; reset is asynchronous and active-low (asserted when 0)
cpu_req  in  1  CPU transaction request; held with its fields stable until cpu_ack
cpu_we  in  2  00 read, 01 word write, 10 byte write, 11 illegal
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data; byte writes use bits 7:0
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  read data, valid in the cpu_ack cycle
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as cpu_* for the debug port
mem_en  out  1  memory access strobe
mem_we  out  1  write strobe, qualified by mem_en
mem_be  out  4  byte enables; bit i covers bits 8i+7:8i
mem_addr  out  AW  word address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid MEM_LAT cycles after the mem_en cycle
owner  out  1  0 = CPU, 1 = debug; owner of the current or last transaction
busy  out  1  1 in every state except IDLE
err  out  1  sticky; set when an illegal we=11 is granted; cleared only by reset

Behaviour:
- Reset values: state IDLE, all ack=0, rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, owner=0, busy=0, err=0.
- Reset sets the last-grant pointer to debug, so the CPU wins the first tie.
- States: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - If any req is high, pick a winner.
  - If only one requester is high, it wins.
  - If both are high, the requester not granted last wins.
  - Latch the winner's we, addr and wdata into registers; update owner and the last-grant pointer; go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_addr = latched addr[AW+1:2].
  - Read: mem_we=0, mem_be=0000.
  - Word write: mem_we=1, mem_be=1111, mem_wdata = latched wdata; addr[1:0] ignored.
  - Byte write: mem_we=1, mem_be = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - Illegal we=11: performed as a read; err is set.
  - Load the counter with MEM_LAT; go to WAIT.
- WAIT:
  - mem_en=0, mem_we=0, mem_be=0; mem_addr and mem_wdata hold their values.
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, register mem_rdata into the owner's rdata; go to ACK.
  - WAIT lasts exactly MEM_LAT cycles.
- ACK (1 cycle):
  - The owner's ack=1; the other requester's ack=0.
  - The owner's rdata holds the captured value; write data is also captured but is don't-care for writes.
  - Go to IDLE.
- Latency: req sampled high in IDLE at cycle 0 → ACCESS at cycle 1 → ack at cycle MEM_LAT+2. Writes have the same latency as reads.
- Minimum gap between grants is one IDLE cycle.
- A requester must drop req in the cycle after ack. If req is still high in that IDLE cycle, it is treated as a new request.
- A req deasserting mid-transaction is ignored: the transaction completes and ack is still issued.
- The non-owner's rdata holds its previous value.
- A request from the other port during a transaction waits. It wins at the next IDLE cycle because the round-robin pointer now favours it.
- Asynchronous reset in any state:
  - Immediately returns to IDLE with the reset values above.
  - The in-flight transaction is abandoned with no ack.
  - A write already strobed in ACCESS may have been committed.

Test Plan:
- MEM_LAT=1; CPU read of addr 0x0000_0010, memory word 4 = 0xDEADBEEF → mem_en high in cycle 1 with mem_addr=4; cpu_ack and cpu_rdata=0xDEADBEEF in cycle 3; dbg_ack stays 0.
- CPU byte write, addr 0x0000_0007, wdata 0x0000_00A5 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=1, mem_we=1 in the ACCESS cycle only; cpu_ack in cycle 3.
- cpu_req and dbg_req both high from reset and re-raised after each ack → grants go CPU, debug, CPU, debug; owner toggles 0,1,0,1; exactly one ack per transaction.
- dbg_we=11 at addr 0x20 → mem_we=0, mem_be=0000; err=1 and stays 1 through later legal transactions until reset.
- MEM_LAT=3; CPU read → ack in cycle 5; a dbg_req raised in cycle 2 is granted in the IDLE cycle after the CPU ack, and dbg_ack arrives 5 cycles later.
- reset driven low during WAIT of a debug read → all outputs return to reset values immediately, no dbg_ack; after reset release, a tie is won by the CPU.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory between the CPU controller and
// a debug/loader port; sequences enable, byte lanes and fixed read latency.
module mem_port_arbiter #(
  parameter int AW      = 10,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [1:0]    cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic [31:0]   cpu_rdata,
  input  logic          dbg_req,
  input  logic [1:0]    dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_ack,
  output logic [31:0]   dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          owner,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          pick_dbg;
  logic [1:0]    w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          unused_addr_bits;

  // last_q = 1 means debug was granted last, so the CPU takes the next tie.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_q);
  assign w_we     = pick_dbg ? dbg_we    : cpu_we;
  assign w_addr   = pick_dbg ? dbg_addr  : cpu_addr;
  assign w_wdata  = pick_dbg ? dbg_wdata : cpu_wdata;

  assign unused_addr_bits = ^{cpu_addr[31:AW+2], dbg_addr[31:AW+2]};

  // Memory strobes are computed at grant time so they appear registered in ACCESS.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d    = ACCESS;
          owner_d    = pick_dbg;
          last_d     = pick_dbg;
          mem_en_d   = 1'b1;
          mem_addr_d = w_addr[AW+1:2];
          case (w_we)
            2'b01: begin
              mem_we_d    = 1'b1;
              mem_be_d    = 4'b1111;
              mem_wdata_d = w_wdata;
            end
            2'b10: begin
              mem_we_d    = 1'b1;
              mem_be_d    = 4'b0001 << w_addr[1:0];
              mem_wdata_d = {4{w_wdata[7:0]}};
            end
            default: begin
              mem_wdata_d = w_wdata;
            end
          endcase
          if (w_we == 2'b11) begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_d   = 3'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (owner_q) begin
            dbg_rdata_d = mem_rdata;
            dbg_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 3'd0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3) with memory models;
// a scoreboard queue of expected acks is drained by a negedge monitor.
module tb_mem_port_arbiter;

  localparam int AW = 10;

  typedef struct {
    int          inst;
    bit          port;
    logic [31:0] rdata;
    bit          chk;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cpu_req [2];
  logic [1:0]    cpu_we [2];
  logic [31:0]   cpu_addr [2];
  logic [31:0]   cpu_wdata [2];
  logic          cpu_ack [2];
  logic [31:0]   cpu_rdata [2];
  logic          dbg_req [2];
  logic [1:0]    dbg_we [2];
  logic [31:0]   dbg_addr [2];
  logic [31:0]   dbg_wdata [2];
  logic          dbg_ack [2];
  logic [31:0]   dbg_rdata [2];
  logic          mem_en [2];
  logic          mem_we [2];
  logic [3:0]    mem_be [2];
  logic [AW-1:0] mem_addr [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];
  logic          owner [2];
  logic          busy [2];
  logic          err [2];

  exp_t exp_q[$];
  exp_t e;
  logic [31:0] got;
  int   checks = 0;
  int   errors = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [31:0] mem [1 << AW];
      logic [31:0] pipe [LAT];

      initial begin
        for (int a = 0; a < (1 << AW); a++)
          mem[a] = (a == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(a));
      end

      always @(posedge clk) begin
        if (mem_en[gi] && mem_we[gi]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[gi][b]) mem[mem_addr[gi]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
        end
        pipe[0] <= mem[mem_addr[gi]];
        for (int p = 1; p < LAT; p++) pipe[p] <= pipe[p-1];
      end
      assign mem_rdata[gi] = pipe[LAT-1];

      mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req[gi]),
        .cpu_we    (cpu_we[gi]),
        .cpu_addr  (cpu_addr[gi]),
        .cpu_wdata (cpu_wdata[gi]),
        .cpu_ack   (cpu_ack[gi]),
        .cpu_rdata (cpu_rdata[gi]),
        .dbg_req   (dbg_req[gi]),
        .dbg_we    (dbg_we[gi]),
        .dbg_addr  (dbg_addr[gi]),
        .dbg_wdata (dbg_wdata[gi]),
        .dbg_ack   (dbg_ack[gi]),
        .dbg_rdata (dbg_rdata[gi]),
        .mem_en    (mem_en[gi]),
        .mem_we    (mem_we[gi]),
        .mem_be    (mem_be[gi]),
        .mem_addr  (mem_addr[gi]),
        .mem_wdata (mem_wdata[gi]),
        .mem_rdata (mem_rdata[gi]),
        .owner     (owner[gi]),
        .busy      (busy[gi]),
        .err       (err[gi])
      );
    end
  endgenerate

  // Monitor: pop one expectation per ack; requesters drop req once acked.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cpu_ack[i] || dbg_ack[i]) begin
        checks++;
        got = dbg_ack[i] ? dbg_rdata[i] : cpu_rdata[i];
        if (cpu_ack[i] && dbg_ack[i]) begin
          errors++;
          $display("FAIL ack_both inst%0d cyc=%0d: both acks high, required one", i, cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected inst%0d cyc=%0d port=%0d rdata=%h, required no ack",
                   i, cyc, dbg_ack[i], got);
        end else begin
          e = exp_q.pop_front();
          if (e.inst != i || e.port != dbg_ack[i] || e.at != cyc || (e.chk && got !== e.rdata)) begin
            errors++;
            $display("FAIL ack got inst%0d port=%0d cyc=%0d rdata=%h, required inst%0d port=%0d cyc=%0d rdata=%h",
                     i, dbg_ack[i], cyc, got, e.inst, e.port, e.at, e.rdata);
          end else begin
            $display("ack inst%0d port=%0d cyc=%0d rdata=%h ok", i, dbg_ack[i], cyc, got);
          end
        end
        if (cpu_ack[i]) cpu_req[i] = 1'b0;
        if (dbg_ack[i]) dbg_req[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, expv);
    end
  endtask

  task automatic issue(input int i, input bit port, input logic [1:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!port) begin
      cpu_we[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = wdata; cpu_req[i] = 1'b1;
    end else begin
      dbg_we[i] = we; dbg_addr[i] = addr; dbg_wdata[i] = wdata; dbg_req[i] = 1'b1;
    end
  endtask

  task automatic expect_ack(input int i, input bit port, input logic [31:0] rdata,
                            input bit chk, input int at);
    exp_t x;
    x.inst = i; x.port = port; x.rdata = rdata; x.chk = chk; x.at = at;
    exp_q.push_back(x);
  endtask

  task automatic wait_idle(input int i);
    for (int t = 0; t < 60; t++) begin
      if (!busy[i] && exp_q.size() == 0 && !cpu_req[i] && !dbg_req[i]) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_idle inst%0d: busy=%0d pending=%0d after 60 cycles, required idle",
             i, busy[i], exp_q.size());
  endtask

  initial begin
    int k;
    int cpu_n;
    int dbg_n;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0;
      dbg_req[i] = 0; dbg_we[i] = 0; dbg_addr[i] = 0; dbg_wdata[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 32'(busy[i]), 0);
      check("rst_mem_en", 32'(mem_en[i]), 0);
      check("rst_owner", 32'(owner[i]), 0);
      check("rst_err", 32'(err[i]), 0);
      check("rst_mem_addr", 32'(mem_addr[i]), 0);
    end
    reset = 1'b1;
    tick();

    // Tie from reset: CPU first, then alternating.
    k = cyc; cpu_n = 1; dbg_n = 1;
    issue(0, 0, 2'b00, 32'h10, 0);
    issue(0, 1, 2'b00, 32'h20, 0);
    expect_ack(0, 0, 32'hDEADBEEF, 1, k + 3);
    expect_ack(0, 1, 32'h1000_0008, 1, k + 7);
    expect_ack(0, 0, 32'hDEADBEEF, 1, k + 11);
    expect_ack(0, 1, 32'h1000_0008, 1, k + 15);
    for (int n = 1; n < 16; n++) begin
      tick();
      if (!cpu_req[0] && cpu_n < 2) begin issue(0, 0, 2'b00, 32'h10, 0); cpu_n++; end
      if (!dbg_req[0] && dbg_n < 2) begin issue(0, 1, 2'b00, 32'h20, 0); dbg_n++; end
      if (n % 4 == 1) check("tie_owner", 32'(owner[0]), 32'((n / 4) % 2));
    end
    wait_idle(0);

    // CPU read of word 4.
    k = cyc;
    issue(0, 0, 2'b00, 32'h10, 0);
    expect_ack(0, 0, 32'hDEADBEEF, 1, k + 3);
    tick();
    check("rd_mem_en", 32'(mem_en[0]), 1);
    check("rd_mem_addr", 32'(mem_addr[0]), 4);
    check("rd_mem_we", 32'(mem_we[0]), 0);
    check("rd_mem_be", 32'(mem_be[0]), 0);
    check("rd_busy", 32'(busy[0]), 1);
    wait_idle(0);

    // CPU byte write to byte 3 of word 1, then read back.
    k = cyc;
    issue(0, 0, 2'b10, 32'h7, 32'h0000_00A5);
    expect_ack(0, 0, 0, 0, k + 3);
    tick();
    check("bw_mem_be", 32'(mem_be[0]), 32'h8);
    check("bw_mem_wdata", mem_wdata[0], 32'hA5A5_A5A5);
    check("bw_mem_addr", 32'(mem_addr[0]), 1);
    check("bw_mem_we", 32'(mem_we[0]), 1);
    tick();
    check("bw_wait_we", 32'(mem_we[0]), 0);
    check("bw_wait_en", 32'(mem_en[0]), 0);
    check("bw_wait_be", 32'(mem_be[0]), 0);
    check("bw_wait_addr", 32'(mem_addr[0]), 1);
    wait_idle(0);
    k = cyc;
    issue(0, 0, 2'b00, 32'h4, 0);
    expect_ack(0, 0, 32'hA500_0001, 1, k + 3);
    wait_idle(0);

    // Illegal we=11 on debug; err sticky across a legal word write.
    check("il_err_before", 32'(err[0]), 0);
    k = cyc;
    issue(0, 1, 2'b11, 32'h20, 32'hFFFF_FFFF);
    expect_ack(0, 1, 32'h1000_0008, 1, k + 3);
    tick();
    check("il_mem_en", 32'(mem_en[0]), 1);
    check("il_mem_we", 32'(mem_we[0]), 0);
    check("il_mem_be", 32'(mem_be[0]), 0);
    check("il_err", 32'(err[0]), 1);
    check("il_owner", 32'(owner[0]), 1);
    wait_idle(0);
    k = cyc;
    issue(0, 0, 2'b01, 32'h32, 32'h1234_5678);
    expect_ack(0, 0, 0, 0, k + 3);
    tick();
    check("ww_mem_be", 32'(mem_be[0]), 32'hF);
    check("ww_mem_addr", 32'(mem_addr[0]), 32'hC);
    check("ww_mem_wdata", mem_wdata[0], 32'h1234_5678);
    wait_idle(0);
    k = cyc;
    issue(0, 0, 2'b00, 32'h30, 0);
    expect_ack(0, 0, 32'h1234_5678, 1, k + 3);
    wait_idle(0);
    check("il_err_sticky", 32'(err[0]), 1);

    // MEM_LAT=3: debug request arriving mid-transaction waits its turn.
    k = cyc;
    issue(1, 0, 2'b00, 32'h10, 0);
    expect_ack(1, 0, 32'hDEADBEEF, 1, k + 5);
    tick();
    tick();
    issue(1, 1, 2'b00, 32'h24, 0);
    expect_ack(1, 1, 32'h1000_0009, 1, k + 11);
    wait_idle(1);

    // Asynchronous reset during WAIT of a debug read.
    k = cyc;
    issue(1, 1, 2'b00, 32'h20, 0);
    repeat (3) tick();
    check("rs_busy_before", 32'(busy[1]), 1);
    reset = 1'b0;
    #1;
    check("rs_busy", 32'(busy[1]), 0);
    check("rs_mem_addr", 32'(mem_addr[1]), 0);
    check("rs_mem_wdata", mem_wdata[1], 0);
    check("rs_owner", 32'(owner[1]), 0);
    check("rs_cpu_rdata", cpu_rdata[1], 0);
    check("rs_dbg_rdata", dbg_rdata[1], 0);
    check("rs_err_inst0", 32'(err[0]), 0);
    dbg_req[1] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    k = cyc;
    issue(1, 0, 2'b00, 32'h10, 0);
    issue(1, 1, 2'b00, 32'h20, 0);
    expect_ack(1, 0, 32'hDEADBEEF, 1, k + 5);
    expect_ack(1, 1, 32'h1000_0008, 1, k + 11);
    tick();
    check("rs_tie_owner", 32'(owner[1]), 0);
    wait_idle(1);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
